// File: rtl/beta_mem_pkg.sv
// beta_mem_pkg: shared types and helpers for the beta_mem_sys memory subsystem.
//   mem_state_t : per-port FSM state (IDLE, WAIT, RESP)
//   WAIT_W      : width of the per-port wait-state counter (0..15 wait cycles)
//   idx_w()     : word-index width for a given array depth
package beta_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int WAIT_W = 4;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// mem_port_fsm: request/ready handshake controller for one memory port.
//
// Handshake: the requester raises req (with we selecting write vs read) and
// holds addr/wdata/we stable until ready. ready is a one-cycle pulse; if req
// is still high in that cycle it is taken as the next request.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req, we        request and kind (we=1 write, else read)
//   addr, wdata    byte address and write data
//   ready          one-cycle completion pulse
//   err            sticky out-of-range flag (only with BETA_MEM_BOUNDS_CHECK_EN)
//   state          current FSM state (debug)
//   mem_en         array access on the coming edge (the edge that enters RESP)
//   mem_we         array write strobe on the coming edge
//   mem_oor        access on the coming edge is out of range (read returns 0)
//   mem_idx        word index for the access
//   mem_wdata      data for the access
//
// Macro BETA_MEM_BOUNDS_CHECK_EN enables out-of-range detection; without it
// high address bits are simply dropped.
module mem_port_fsm
    import beta_mem_pkg::*;
#(
    parameter int AW       = 10,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              err,
    output mem_state_t        state,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_oor,
    output logic [AW-1:0]     mem_idx,
    output logic [DATA_W-1:0] mem_wdata
);

`ifdef BETA_MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic [WAIT_W-1:0] cnt;
    logic [AW-1:0]     cap_idx;
    logic [DATA_W-1:0] cap_wdata;
    logic              cap_we;
    logic              cap_oor;

    logic              in_oor;
    logic              use_cap;
    logic              go_resp;

    assign in_oor = |(addr >> (AW + 2));

    // go_resp marks the edge that enters RESP: the array is accessed on it.
    // From WAIT the captured request is used, otherwise the live inputs.
    always_comb begin
        use_cap = 1'b0;
        go_resp = 1'b0;
        case (state)
            IDLE, RESP: go_resp = req && (WAIT_CYC == 0);
            WAIT: begin
                use_cap = 1'b1;
                go_resp = (cnt == '0);
            end
            default: go_resp = 1'b0;
        endcase
        // Under reset nothing commits, so a write caught in WAIT is dropped.
        go_resp   = go_resp && !rst;
        mem_en    = go_resp;
        mem_oor   = BOUNDS_EN && (use_cap ? cap_oor : in_oor);
        mem_idx   = use_cap ? cap_idx : addr[AW+1:2];
        mem_wdata = use_cap ? cap_wdata : wdata;
        mem_we    = go_resp && (use_cap ? cap_we : we) && !mem_oor;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_we    <= 1'b0;
            cap_oor   <= 1'b0;
        end else begin
            ready <= go_resp;
            if (go_resp && mem_oor) begin
                err <= 1'b1;
            end
            case (state)
                IDLE, RESP: begin
                    if (req) begin
                        cap_idx   <= addr[AW+1:2];
                        cap_wdata <= wdata;
                        cap_we    <= we;
                        cap_oor   <= in_oor;
                        if (WAIT_CYC == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_W'(WAIT_CYC - 1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/beta_mem_sys.sv
// beta_mem_sys: dual-port memory for the Beta core. One instruction read port
// and one data read/write port share a single word array; each port has its
// own wait-state count and request/ready handshake.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_mem_req, i_mem_r_addr       instruction read request, byte address
//   i_mem_r_data, i_mem_ready     read data (valid while ready), done pulse
//   i_mem_err                     sticky out-of-range flag
//   d_mem_we, d_mem_oe            data write / read request (write wins)
//   d_mem_w_addr, d_mem_w_data    byte address and write data
//   d_mem_r_data, d_mem_ready     read/write-through data, done pulse
//   d_mem_err                     sticky out-of-range flag
//   i_dbg_state, d_dbg_state      per-port FSM state (debug)
//
// Macro BETA_MEM_BOUNDS_CHECK_EN: out-of-range accesses read 0, suppress
// writes and set *_err. Without it addresses wrap modulo the array size.
module beta_mem_sys
    import beta_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int I_WAIT = 0,
    parameter int D_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_req,
    input  logic [31:0]       i_mem_r_addr,
    output logic [DATA_W-1:0] i_mem_r_data,
    output logic              i_mem_ready,
    output logic              i_mem_err,
    input  logic              d_mem_we,
    input  logic              d_mem_oe,
    input  logic [31:0]       d_mem_w_addr,
    input  logic [DATA_W-1:0] d_mem_w_data,
    output logic [DATA_W-1:0] d_mem_r_data,
    output logic              d_mem_ready,
    output logic              d_mem_err,
    output mem_state_t        i_dbg_state,
    output mem_state_t        d_dbg_state
);

    localparam int AW = idx_w(DEPTH);

    logic [DATA_W-1:0] mem_array [DEPTH];

    logic              i_arr_en, i_arr_we, i_arr_oor;
    logic [AW-1:0]     i_arr_idx;
    logic [DATA_W-1:0] i_arr_wdata;

    logic              d_arr_en, d_arr_we, d_arr_oor;
    logic [AW-1:0]     d_arr_idx;
    logic [DATA_W-1:0] d_arr_wdata;

    mem_port_fsm #(
        .AW       (AW),
        .DATA_W   (DATA_W),
        .WAIT_CYC (I_WAIT)
    ) u_i_port (
        .clk       (clk),
        .rst       (rst),
        .req       (i_mem_req),
        .we        (1'b0),
        .addr      (i_mem_r_addr),
        .wdata     ('0),
        .ready     (i_mem_ready),
        .err       (i_mem_err),
        .state     (i_dbg_state),
        .mem_en    (i_arr_en),
        .mem_we    (i_arr_we),
        .mem_oor   (i_arr_oor),
        .mem_idx   (i_arr_idx),
        .mem_wdata (i_arr_wdata)
    );

    mem_port_fsm #(
        .AW       (AW),
        .DATA_W   (DATA_W),
        .WAIT_CYC (D_WAIT)
    ) u_d_port (
        .clk       (clk),
        .rst       (rst),
        .req       (d_mem_we | d_mem_oe),
        .we        (d_mem_we),
        .addr      (d_mem_w_addr),
        .wdata     (d_mem_w_data),
        .ready     (d_mem_ready),
        .err       (d_mem_err),
        .state     (d_dbg_state),
        .mem_en    (d_arr_en),
        .mem_we    (d_arr_we),
        .mem_oor   (d_arr_oor),
        .mem_idx   (d_arr_idx),
        .mem_wdata (d_arr_wdata)
    );

    // Only the data port writes. The array has no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (d_arr_we) begin
            mem_array[d_arr_idx] <= d_arr_wdata;
        end
    end

    // Registered read outputs. Non-blocking semantics give the I port the
    // pre-write word when both ports hit the same word on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_mem_r_data <= '0;
            d_mem_r_data <= '0;
        end else begin
            if (i_arr_en) begin
                i_mem_r_data <= i_arr_oor ? '0 : mem_array[i_arr_idx];
            end
            if (d_arr_en) begin
                if (d_arr_oor) begin
                    d_mem_r_data <= '0;
                end else if (d_arr_we) begin
                    d_mem_r_data <= d_arr_wdata;
                end else begin
                    d_mem_r_data <= mem_array[d_arr_idx];
                end
            end
        end
    end

    // The I port never writes; its write-side outputs are intentionally idle.
    logic unused_i_write;
    assign unused_i_write = i_arr_we | (|i_arr_wdata);

endmodule
